// File: rtl/conv_layer_calc_pkg.sv
// Shared constants and elaboration helpers for the convolution MAC engine
// and its parent convolution element.
package conv_layer_calc_pkg;

  localparam int PROD_W = 8;

  function automatic int prod_width(input int n, input int m);
    return n + m;
  endfunction

  function automatic int kernel_to_e(input int kernel);
    int e;
    e = 32'sd0;
    case (kernel)
      32'sd1:  e = 32'sd1;
      32'sd3:  e = 32'sd3;
      32'sd5:  e = 32'sd4;
      32'sd7:  e = 32'sd5;
      default: e = 32'sd0;
    endcase
    return e;
  endfunction

  function automatic bit kernel_legal(input int kernel);
    return (kernel_to_e(kernel) != 32'sd0);
  endfunction

  // Extra bits the parent needs when summing one partial sum per channel.
  function automatic int channels_to_e2(input int channels);
    return (channels <= 32'sd1) ? 32'sd0 : $clog2(channels);
  endfunction

endpackage

// File: rtl/conv_calc_adder_tree.sv
// Balanced adder tree over NUM operands of IN_W bits, built by recursive
// halving; the sum wraps modulo 2^OUT_W.
module conv_calc_adder_tree #(
  parameter int NUM   = 9,
  parameter int IN_W  = 8,
  parameter int OUT_W = 11
) (
  input  logic [NUM*IN_W-1:0] operands,
  output logic [OUT_W-1:0]    sum
);

  if (NUM == 1) begin : g_leaf
    assign sum = OUT_W'(operands);
  end else begin : g_node
    localparam int NUM_LO = NUM / 2;
    localparam int NUM_HI = NUM - NUM_LO;

    logic [OUT_W-1:0] sum_lo_s;
    logic [OUT_W-1:0] sum_hi_s;

    conv_calc_adder_tree #(.NUM(NUM_LO), .IN_W(IN_W), .OUT_W(OUT_W)) u_lo (
      .operands (operands[NUM_LO*IN_W-1:0]),
      .sum      (sum_lo_s)
    );

    conv_calc_adder_tree #(.NUM(NUM_HI), .IN_W(IN_W), .OUT_W(OUT_W)) u_hi (
      .operands (operands[NUM*IN_W-1:NUM_LO*IN_W]),
      .sum      (sum_hi_s)
    );

    assign sum = sum_lo_s + sum_hi_s;
  end

endmodule

// File: rtl/conv_layer_calc.sv
// Per-channel KERNEL x KERNEL multiply-accumulate engine.
// Define CONV_LAYER_CALC_PIPE_EN to add a product register stage (latency 2).
module conv_layer_calc
  import conv_layer_calc_pkg::*;
#(
  parameter int KERNEL = 3,
  parameter int E      = 3,
  parameter int N      = 4,
  parameter int M      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [KERNEL*KERNEL*N-1:0] data2conv,
  input  logic                       en_in,
  input  logic [KERNEL*KERNEL*M-1:0] w,
  output logic [N+M+E-1:0]           d_out,
  output logic                       en_out
);

  localparam int TAPS  = KERNEL * KERNEL;
  localparam int P_W   = prod_width(N, M);
  localparam int OUT_W = N + M + E;

  if (!kernel_legal(KERNEL)) begin : g_bad_kernel
    $error("conv_layer_calc: KERNEL must be 1, 3, 5 or 7");
  end

  logic [TAPS*P_W-1:0] prod_s;
  logic [TAPS*P_W-1:0] tree_in_s;
  logic                stage_vld_s;
  logic [OUT_W-1:0]    tree_sum_s;

  for (genvar j = 0; j < TAPS; j++) begin : g_prod
    assign prod_s[j*P_W +: P_W] = P_W'(data2conv[j*N +: N]) * P_W'(w[j*M +: M]);
  end

`ifdef CONV_LAYER_CALC_PIPE_EN
  logic [TAPS*P_W-1:0] prod_r;
  logic                prod_vld_r;

  // Product stage: loads only on a valid window, holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r     <= '0;
      prod_vld_r <= 1'b0;
    end else begin
      prod_vld_r <= en_in;
      if (en_in) begin
        prod_r <= prod_s;
      end
    end
  end

  assign tree_in_s   = prod_r;
  assign stage_vld_s = prod_vld_r;
`else
  assign tree_in_s   = prod_s;
  assign stage_vld_s = en_in;
`endif

  conv_calc_adder_tree #(.NUM(TAPS), .IN_W(P_W), .OUT_W(OUT_W)) u_tree (
    .operands (tree_in_s),
    .sum      (tree_sum_s)
  );

  // Output stage: d_out keeps the last valid sum between strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out  <= '0;
      en_out <= 1'b0;
    end else begin
      en_out <= stage_vld_s;
      if (stage_vld_s) begin
        d_out <= tree_sum_s;
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_calc.sv
// Directed self-checking bench for conv_layer_calc (K=3 and K=5 instances);
// latency follows CONV_LAYER_CALC_PIPE_EN.
module tb_conv_layer_calc;

`ifdef CONV_LAYER_CALC_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst;
  logic [35:0]  data3;
  logic [35:0]  w3;
  logic         en3;
  logic [10:0]  d_out3;
  logic         en_out3;
  logic [99:0]  data5;
  logic [99:0]  w5;
  logic         en5;
  logic [11:0]  d_out5;
  logic         en_out5;

  int n_tests;
  int n_fail;

  logic [35:0] win_d   [0:3];
  logic [35:0] win_w   [0:3];
  logic [10:0] win_exp [0:3];
  int          nwin;

  conv_layer_calc #(.KERNEL(3), .E(3), .N(4), .M(4)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .data2conv (data3),
    .en_in     (en3),
    .w         (w3),
    .d_out     (d_out3),
    .en_out    (en_out3)
  );

  conv_layer_calc #(.KERNEL(5), .E(4), .N(4), .M(4)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .data2conv (data5),
    .en_in     (en5),
    .w         (w5),
    .d_out     (d_out5),
    .en_out    (en_out5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] uniform9(input logic [3:0] v);
    logic [35:0] r;
    for (int j = 0; j < 9; j++) r[j*4 +: 4] = v;
    return r;
  endfunction

  function automatic logic [35:0] tap9(input int idx, input logic [3:0] v);
    logic [35:0] r;
    r = '0;
    r[idx*4 +: 4] = v;
    return r;
  endfunction

  // Drives win_* back-to-back and checks en_out/d_out every cycle, incl. hold.
  task automatic run_stream(input string tag, input logic [10:0] prev);
    int   idx;
    logic exp_en;
    logic [10:0] exp_d;
    for (int c = 0; c < nwin + LAT + 2; c++) begin
      @(negedge clk);
      idx    = c - LAT;
      exp_en = (idx >= 0) && (idx < nwin);
      if (idx < 0)         exp_d = prev;
      else if (idx < nwin) exp_d = win_exp[idx];
      else                 exp_d = win_exp[nwin-1];
      check_val($sformatf("%s_en_c%0d", tag, c), 32'(en_out3), 32'(exp_en));
      check_val($sformatf("%s_d_c%0d", tag, c), 32'(d_out3), 32'(exp_d));
      if (c < nwin) begin
        data3 = win_d[c];
        w3    = win_w[c];
        en3   = 1'b1;
      end else begin
        data3 = '0;
        w3    = '0;
        en3   = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    data3 = '0; w3 = '0; en3 = 1'b0;
    data5 = '0; w5 = '0; en5 = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_d3",  32'(d_out3),  32'd0);
    check_val("rst_en3", 32'(en_out3), 32'd0);
    check_val("rst_d5",  32'(d_out5),  32'd0);
    check_val("rst_en5", 32'(en_out5), 32'd0);
    rst = 1'b0;

    nwin = 1;
    win_d[0] = uniform9(4'd1);  win_w[0] = uniform9(4'd1);  win_exp[0] = 11'd9;
    run_stream("unit", 11'd0);

    win_d[0] = uniform9(4'd15); win_w[0] = uniform9(4'd15); win_exp[0] = 11'd2025;
    run_stream("full", 11'd9);

    win_d[0] = tap9(4, 4'd7);   win_w[0] = tap9(4, 4'd3);   win_exp[0] = 11'd21;
    run_stream("tap4", 11'd2025);

    win_d[0] = tap9(8, 4'd15);  win_w[0] = tap9(8, 4'd2);   win_exp[0] = 11'd30;
    run_stream("tap8", 11'd21);

    nwin = 3;
    win_d[0] = uniform9(4'd1);  win_w[0] = uniform9(4'd1);  win_exp[0] = 11'd9;
    win_d[1] = tap9(4, 4'd7);   win_w[1] = tap9(4, 4'd3);   win_exp[1] = 11'd21;
    win_d[2] = uniform9(4'd15); win_w[2] = uniform9(4'd15); win_exp[2] = 11'd2025;
    run_stream("stream", 11'd30);

    // K=5 full scale: 25*225 = 5625 wraps to 1529 in 12 bits
    @(negedge clk);
    data5 = {100{1'b1}};
    w5    = {100{1'b1}};
    en5   = 1'b1;
    @(negedge clk);
    en5 = 1'b0;
    if (LAT == 2) begin
      check_val("wrap_en_early", 32'(en_out5), 32'd0);
      @(negedge clk);
    end
    check_val("wrap_en", 32'(en_out5), 32'd1);
    check_val("wrap_d",  32'(d_out5),  32'd1529);
    @(negedge clk);
    check_val("wrap_en_off", 32'(en_out5), 32'd0);
    check_val("wrap_hold",   32'(d_out5),  32'd1529);

    // Reset while a window is in flight
    data3 = uniform9(4'd1);
    w3    = uniform9(4'd1);
    en3   = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_d",  32'(d_out3),  32'd0);
    check_val("midrst_en", 32'(en_out3), 32'd0);
    @(negedge clk);
    en3   = 1'b0;
    data3 = '0;
    w3    = '0;
    rst   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val($sformatf("postrst_en_%0d", i), 32'(en_out3), 32'd0);
      check_val($sformatf("postrst_d_%0d", i),  32'(d_out3),  32'd0);
    end

    nwin = 1;
    win_d[0] = uniform9(4'd1);  win_w[0] = uniform9(4'd1);  win_exp[0] = 11'd9;
    run_stream("after_rst", 11'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_layer_calc.md
# conv_layer_calc

Per-channel convolution multiply-accumulate engine. Each instance takes one KERNEL×KERNEL window of unsigned input features and the matching weights, forms all element-wise products, and reduces them to a single partial sum. The convolution element instantiates one of these per input channel and combines their outputs with a carry-save adder.

## Interface

Parameters:
- KERNEL, default 3: window side length; legal values 1, 3, 5, 7.
- E, default 3: extra sum bits above N+M. The parent uses E=1 for K=1, 3 for K=3, 4 for K=5 and 5 for K=7.
- N, default 4: data element width.
- M, default 4: weight element width.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- data2conv, input, KERNEL*KERNEL*N: window data. Element j is at bits [j*N +: N], in row-major order.
- en_in, input, 1: input valid for this cycle.
- w, input, KERNEL*KERNEL*M: weights. Element j is at bits [j*M +: M], in the same order as data.
- d_out, output, N+M+E: accumulated sum.
- en_out, output, 1: d_out valid strobe.

## Operation

- All operands are unsigned.
- p[j] = data[j] * w[j], at full N+M width, for j = 0 … KERNEL²−1.
- d_out = Σ p[j] mod 2^(N+M+E).
  - Overflow wraps silently; there is no saturation and no overflow flag.
  - Example: K=5 with E=4 can overflow at full-scale inputs.
- KERNEL=1: d_out is the single product zero-extended to N+M+E bits.
- Pipeline registers load only when their stage-valid bit is 1. Otherwise they hold.
  - d_out therefore holds the last valid result until the next en_out.
- No backpressure. A new window is accepted every cycle en_in=1. Back-to-back inputs produce back-to-back outputs.
- Reset asserted mid-operation discards all in-flight windows. en_out stays 0 until new en_in samples have traversed the pipeline.

## Timing

- Reset values: d_out=0, en_out=0, all internal stage registers and valid bits 0. Reset takes effect asynchronously; release is synchronous to clk.
- Latency with CONV_LAYER_CALC_PIPE_EN defined: 2 cycles.
  - Cycle 1: register the products and stage valid.
  - Cycle 2: register the adder-tree sum into d_out and set en_out.
- Latency without the macro: 1 cycle. Products and adder tree are combinational into the d_out register.
- en_out is en_in delayed by exactly the latency, one pulse per accepted window.
- d_out is registered only; there is no combinational input-to-output path.

## Configuration

- CONV_LAYER_CALC_PIPE_EN defined: product register stage present, latency 2.
- CONV_LAYER_CALC_PIPE_EN undefined: product register stage absent, latency 1.
- The arithmetic result is identical in both cases.

## Structure

- Shared package holds:
  - the kernel-to-E function (1→1, 3→3, 5→4, 7→5);
  - the legal-KERNEL check, which must raise an elaboration error for other values;
  - the product-width constant N+M.
- The parent's channel-count-to-E2 mapping lives in the same package.
- One natural sub-module: conv_calc_adder_tree.
  - A parameterised balanced adder tree over KERNEL² operands of N+M bits.
  - Output is N+M+E bits, truncated.
- Products are generated in a for-generate loop in conv_layer_calc.

## Test plan

Default configuration (N=M=4, KERNEL=3, E=3, macro defined) unless stated:
- Reset: assert rst mid-stream → d_out=0 and en_out=0 immediately. No en_out until 2 cycles after the next en_in.
- Unit window: all data=1, all w=1, en_in high for one cycle → d_out=9 with a single en_out pulse, 2 cycles later.
- Full scale: all data=15, all w=15 → d_out=2025 (no overflow).
- Single tap: data[4]=7, w[4]=3, all others 0 → d_out=21. Then data[8]=15, w[8]=2, others 0 → d_out=30.
- Wrap: KERNEL=5, E=4, all operands 15 → d_out=5625 mod 4096=1529.
- Streaming and hold:
  - three consecutive windows giving 9, 21, 2025 → three consecutive en_out pulses with those values;
  - then en_in=0 → d_out holds 2025 and en_out=0.
  - Repeat with the macro undefined → latency 1, same values.
